// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter with independent round-robin read and write channels.
// Optional AXI_ARB_IDTAG_EN: slave IDs carry the grant index; mismatched responses are dropped and flagged on err_tag.
module axi_rr_arbiter #(
  parameter  int NUM_M  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int ID_W   = 4,
  localparam int GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
`ifdef AXI_ARB_IDTAG_EN
  localparam int S_ID_W = ID_W + GW,
`else
  localparam int S_ID_W = ID_W,
`endif
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef AXI_ARB_IDTAG_EN
  output logic                     err_tag,
`endif
  // master AR / R
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M*ID_W-1:0]   m_arid,
  input  logic [NUM_M*8-1:0]      m_arlen,
  input  logic [NUM_M*3-1:0]      m_arsize,
  input  logic [NUM_M*2-1:0]      m_arburst,
  input  logic [NUM_M-1:0]        m_arvalid,
  output logic [NUM_M-1:0]        m_arready,
  output logic [NUM_M*DATA_W-1:0] m_rdata,
  output logic [NUM_M*2-1:0]      m_rresp,
  output logic [NUM_M-1:0]        m_rlast,
  output logic [NUM_M*ID_W-1:0]   m_rid,
  output logic [NUM_M-1:0]        m_rvalid,
  input  logic [NUM_M-1:0]        m_rready,
  // master AW / W / B
  input  logic [NUM_M*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_M*ID_W-1:0]   m_awid,
  input  logic [NUM_M*8-1:0]      m_awlen,
  input  logic [NUM_M*3-1:0]      m_awsize,
  input  logic [NUM_M*2-1:0]      m_awburst,
  input  logic [NUM_M-1:0]        m_awvalid,
  output logic [NUM_M-1:0]        m_awready,
  input  logic [NUM_M*DATA_W-1:0] m_wdata,
  input  logic [NUM_M*STRB_W-1:0] m_wstrb,
  input  logic [NUM_M-1:0]        m_wlast,
  input  logic [NUM_M-1:0]        m_wvalid,
  output logic [NUM_M-1:0]        m_wready,
  output logic [NUM_M*2-1:0]      m_bresp,
  output logic [NUM_M*ID_W-1:0]   m_bid,
  output logic [NUM_M-1:0]        m_bvalid,
  input  logic [NUM_M-1:0]        m_bready,
  // slave AR / R
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [S_ID_W-1:0]       s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic [S_ID_W-1:0]       s_rid,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  // slave AW / W / B
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic [S_ID_W-1:0]       s_awid,
  output logic [7:0]              s_awlen,
  output logic [2:0]              s_awsize,
  output logic [1:0]              s_awburst,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [STRB_W-1:0]       s_wstrb,
  output logic                    s_wlast,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic [S_ID_W-1:0]       s_bid,
  input  logic                    s_bvalid,
  output logic                    s_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

  r_state_t        r_rstate;
  w_state_t        r_wstate;
  logic [GW-1:0]   r_rg;
  logic [GW-1:0]   r_rptr;
  logic [GW-1:0]   r_wg;
  logic [GW-1:0]   r_wptr;
  logic            r_aw_done;
  logic            r_w_done;

  logic            w_r_tag_ok;
  logic            w_b_tag_ok;
  logic            w_ar_fire;
  logic            w_r_done;
  logic            w_aw_fire;
  logic            w_wlast_fire;
  logic            w_b_done;

  // First requester at or after ptr, scanning cyclically.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_M-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(ptr) + k) % NUM_M;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return GW'((int'(g) + 1) % NUM_M);
  endfunction

`ifdef AXI_ARB_IDTAG_EN
  logic r_err_tag;
  assign w_r_tag_ok = (s_rid[S_ID_W-1 -: GW] == r_rg);
  assign w_b_tag_ok = (s_bid[S_ID_W-1 -: GW] == r_wg);
  assign err_tag    = r_err_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_tag <= 1'b0;
    end else begin
      r_err_tag <= ((r_rstate == R_DATA) && s_rvalid && !w_r_tag_ok) ||
                   ((r_wstate == W_RESP) && s_bvalid && !w_b_tag_ok);
    end
  end
`else
  assign w_r_tag_ok = 1'b1;
  assign w_b_tag_ok = 1'b1;
`endif

  // ---------------- read path ----------------
  always_comb begin
    // NOTE: every output gets a default before the state-dependent overrides, so no latch is inferred.
    s_araddr  = m_araddr[r_rg*ADDR_W +: ADDR_W];
`ifdef AXI_ARB_IDTAG_EN
    s_arid    = {r_rg, m_arid[r_rg*ID_W +: ID_W]};
`else
    s_arid    = m_arid[r_rg*ID_W +: ID_W];
`endif
    s_arlen   = m_arlen[r_rg*8 +: 8];
    s_arsize  = m_arsize[r_rg*3 +: 3];
    s_arburst = m_arburst[r_rg*2 +: 2];
    s_arvalid = (r_rstate == R_ADDR) && m_arvalid[r_rg];
    m_arready = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = '0;
    m_rid     = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    if (r_rstate == R_ADDR) begin
      m_arready[r_rg] = s_arready;
    end
    if (r_rstate == R_DATA) begin
      if (w_r_tag_ok) begin
        m_rdata[r_rg*DATA_W +: DATA_W] = s_rdata;
        m_rresp[r_rg*2 +: 2]           = s_rresp;
        m_rlast[r_rg]                  = s_rlast;
        m_rid[r_rg*ID_W +: ID_W]       = s_rid[ID_W-1:0];
        m_rvalid[r_rg]                 = s_rvalid;
        s_rready                       = m_rready[r_rg];
      end else begin
        s_rready = 1'b1;
      end
    end
  end

  assign w_ar_fire = s_arvalid && s_arready;
  assign w_r_done  = (r_rstate == R_DATA) && s_rvalid && s_rready && s_rlast && w_r_tag_ok;

  // NOTE: state registers use non-blocking assignments; only the FSM registers are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rg     <= '0;
      r_rptr   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (|m_arvalid) begin
          r_rg     <= rr_pick(m_arvalid, r_rptr);
          r_rstate <= R_ADDR;
        end
        R_ADDR: if (w_ar_fire) r_rstate <= R_DATA;
        R_DATA: if (w_r_done) begin
          r_rptr   <= rr_next(r_rg);
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  always_comb begin
    s_awaddr  = m_awaddr[r_wg*ADDR_W +: ADDR_W];
`ifdef AXI_ARB_IDTAG_EN
    s_awid    = {r_wg, m_awid[r_wg*ID_W +: ID_W]};
`else
    s_awid    = m_awid[r_wg*ID_W +: ID_W];
`endif
    s_awlen   = m_awlen[r_wg*8 +: 8];
    s_awsize  = m_awsize[r_wg*3 +: 3];
    s_awburst = m_awburst[r_wg*2 +: 2];
    s_awvalid = (r_wstate == W_XFER) && !r_aw_done && m_awvalid[r_wg];
    s_wdata   = m_wdata[r_wg*DATA_W +: DATA_W];
    s_wstrb   = m_wstrb[r_wg*STRB_W +: STRB_W];
    s_wlast   = m_wlast[r_wg];
    s_wvalid  = (r_wstate == W_XFER) && !r_w_done && m_wvalid[r_wg];
    m_awready = '0;
    m_wready  = '0;
    m_bresp   = '0;
    m_bid     = '0;
    m_bvalid  = '0;
    s_bready  = 1'b0;
    if (r_wstate == W_XFER) begin
      m_awready[r_wg] = s_awready && !r_aw_done;
      m_wready[r_wg]  = s_wready && !r_w_done;
    end
    if (r_wstate == W_RESP) begin
      if (w_b_tag_ok) begin
        m_bresp[r_wg*2 +: 2]     = s_bresp;
        m_bid[r_wg*ID_W +: ID_W] = s_bid[ID_W-1:0];
        m_bvalid[r_wg]           = s_bvalid;
        s_bready                 = m_bready[r_wg];
      end else begin
        s_bready = 1'b1;
      end
    end
  end

  assign w_aw_fire    = s_awvalid && s_awready;
  assign w_wlast_fire = s_wvalid && s_wready && s_wlast;
  assign w_b_done     = (r_wstate == W_RESP) && s_bvalid && s_bready && w_b_tag_ok;

  // AW and W complete independently; the response phase starts once both have.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wg      <= '0;
      r_wptr    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (|m_awvalid) begin
          r_wg     <= rr_pick(m_awvalid, r_wptr);
          r_wstate <= W_XFER;
        end
        W_XFER: begin
          if ((r_aw_done || w_aw_fire) && (r_w_done || w_wlast_fire)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_fire)    r_aw_done <= 1'b1;
            if (w_wlast_fire) r_w_done  <= 1'b1;
          end
        end
        W_RESP: if (w_b_done) begin
          r_wptr   <= rr_next(r_wg);
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter with three masters.
// Covers reset, read round-robin, split AW/W ordering, concurrent backpressure and mid-burst reset.
module tb_axi_rr_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int SB  = DW / 8;
  localparam int GW  = 2;
`ifdef AXI_ARB_IDTAG_EN
  localparam int SIW = IW + GW;
`else
  localparam int SIW = IW;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N*IW-1:0] m_arid, m_awid, m_rid, m_bid;
  logic [N*8-1:0]  m_arlen, m_awlen;
  logic [N*3-1:0]  m_arsize, m_awsize;
  logic [N*2-1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic [N-1:0]    m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*DW-1:0] m_rdata, m_wdata;
  logic [N*SB-1:0] m_wstrb;
  logic [AW-1:0]   s_araddr, s_awaddr;
  logic [SIW-1:0]  s_arid, s_rid, s_awid, s_bid;
  logic [7:0]      s_arlen, s_awlen;
  logic [2:0]      s_arsize, s_awsize;
  logic [1:0]      s_arburst, s_awburst, s_rresp, s_bresp;
  logic            s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0]   s_rdata, s_wdata;
  logic [SB-1:0]   s_wstrb;
`ifdef AXI_ARB_IDTAG_EN
  logic            err_tag;
`endif

  axi_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
`ifdef AXI_ARB_IDTAG_EN
    .err_tag(err_tag),
`endif
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bid(m_bid), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid),
    .s_bready(s_bready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave-side ID seen for master g with master ID id (grant tag prepended when tagging is enabled).
  function automatic logic [SIW-1:0] sid(input int g, input logic [IW-1:0] id);
    return SIW'((longint'(g) << IW) | longint'(id));
  endfunction

  task automatic clear_inputs();
    m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = '0;
    m_rready = '0;
    m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bid = '0; s_bvalid = 1'b0;
  endtask

  task automatic set_ar(input int m, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    m_araddr[m*AW +: AW] = addr;
    m_arid[m*IW +: IW]   = id;
    m_arlen[m*8 +: 8]    = 8'd3;
    m_arsize[m*3 +: 3]   = 3'd2;
    m_arburst[m*2 +: 2]  = 2'b01;
  endtask

  task automatic set_aw(input int m, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    m_awaddr[m*AW +: AW] = addr;
    m_awid[m*IW +: IW]   = id;
    m_awlen[m*8 +: 8]    = 8'd1;
    m_awsize[m*3 +: 3]   = 3'd2;
    m_awburst[m*2 +: 2]  = 2'b01;
    m_wstrb[m*SB +: SB]  = '1;
  endtask

  // Called in R_IDLE with master m requesting; runs the full read and returns in R_IDLE.
  task automatic do_read(input int m, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input int beats, input logic [DW-1:0] dbase);
    tick();
    check("ar_grant", m_arready, 64'(1 << m));
    check("s_araddr", s_araddr, addr);
    check("s_arid", s_arid, sid(m, id));
    tick();
    check("ar_closed", m_arready, 0);
    for (int b = 0; b < beats; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = dbase + DW'(b);
      s_rlast  = (b == beats - 1);
      s_rid    = sid(m, id);
      #1;
      check("r_route", m_rvalid, 64'(1 << m));
      check("r_data", m_rdata[m*DW +: DW], dbase + DW'(b));
      check("r_last", m_rlast, s_rlast ? 64'(1 << m) : 64'd0);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    check("r_idle_rready", s_rready, 0);
  endtask

  initial begin
    // Reset with busy-looking inputs on every side.
    clear_inputs();
    rst       = 1'b1;
    m_arvalid = '1; m_awvalid = '1; m_wvalid = '1; m_rready = '1; m_bready = '1;
    m_araddr  = {$urandom, $urandom, $urandom};
    m_wdata   = {$urandom, $urandom, $urandom};
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rvalid  = 1'b1; s_bvalid = 1'b1; s_rlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_awvalid", s_awvalid, 0);
    check("rst_s_wvalid", s_wvalid, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_s_bready", s_bready, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_awready", m_awready, 0);
    check("rst_m_wready", m_wready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_m_bvalid", m_bvalid, 0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // M0 and M1 request together: M0 first (4 beats), then M1 while M0 keeps requesting.
    set_ar(0, 32'h0000_1000, 4'h3);
    set_ar(1, 32'h0000_2000, 4'h7);
    m_arvalid = 3'b011;
    s_arready = 1'b1;
    m_rready  = 3'b111;
    #1;
    check("grant_latency", s_arvalid, 0);
    do_read(0, 32'h0000_1000, 4'h3, 4, 32'hA000_0000);
    do_read(1, 32'h0000_2000, 4'h7, 4, 32'hB000_0000);

    // All three request continuously; pointer now sits at 2.
    set_ar(2, 32'h0000_3000, 4'hC);
    m_arvalid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      case ((2 + k) % 3)
        0:       do_read(0, 32'h0000_1000, 4'h3, 1, 32'hC000_0000 + DW'(k));
        1:       do_read(1, 32'h0000_2000, 4'h7, 1, 32'hC000_0000 + DW'(k));
        default: do_read(2, 32'h0000_3000, 4'hC, 1, 32'hC000_0000 + DW'(k));
      endcase
    end
    m_arvalid = '0;

    // M1 write: two W beats go through while AW is held off by the slave.
    set_aw(1, 32'h0000_5000, 4'h9);
    m_awvalid = 3'b010;
    m_wvalid  = 3'b010;
    m_wdata[1*DW +: DW] = 32'h1111_0000;
    m_wlast   = 3'b000;
    m_bready  = 3'b111;
    s_awready = 1'b0;
    s_wready  = 1'b1;
    #1;
    check("w_idle", s_wvalid, 0);
    tick();
    check("w_beat0_valid", s_wvalid, 1);
    check("w_beat0_data", s_wdata, 32'h1111_0000);
    check("w_beat0_ready", m_wready, 3'b010);
    check("aw_stalled", m_awready, 0);
    check("s_awid", s_awid, sid(1, 4'h9));
    tick();
    m_wdata[1*DW +: DW] = 32'h2222_0001;
    m_wlast   = 3'b010;
    #1;
    check("w_beat1_data", s_wdata, 32'h2222_0001);
    check("w_beat1_last", s_wlast, 1);
    tick();
    m_wvalid  = '0;
    m_wlast   = '0;
    s_bvalid  = 1'b1;
    s_bresp   = 2'b10;
    s_bid     = sid(1, 4'h9);
    #1;
    check("w_done_hold", s_wvalid, 0);
    check("no_b_before_aw", m_bvalid, 0);
    s_awready = 1'b1;
    #1;
    check("aw_accept", m_awready, 3'b010);
    tick();
    m_awvalid = '0;
    #1;
    check("b_route", m_bvalid, 3'b010);
    check("b_resp_m1", m_bresp, 6'b00_10_00);
    check("b_id_m1", m_bid[1*IW +: IW], 4'h9);
    check("b_bready", s_bready, 1);
    tick();
    s_bvalid = 1'b0;
    #1;
    check("b_idle", s_bready, 0);

    // Concurrent M0 read and M1 write with cross-wired and then correct backpressure.
    set_ar(0, 32'h0000_4000, 4'h1);
    set_aw(1, 32'h0000_6000, 4'h2);
    m_wdata[1*DW +: DW] = 32'h5555_AAAA;
    m_wlast   = 3'b010;
    m_arvalid = 3'b001; m_awvalid = 3'b010; m_wvalid = 3'b010;
    m_rready  = 3'b000; m_bready = 3'b000;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    tick();
    check("cc_arready", m_arready, 3'b001);
    check("cc_awready", m_awready, 3'b010);
    check("cc_wready", m_wready, 3'b010);
    check("cc_wdata", s_wdata, 32'h5555_AAAA);
    tick();
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b1; s_rid = sid(0, 4'h1); s_rresp = 2'b00;
    s_bvalid = 1'b1; s_bresp = 2'b01; s_bid = sid(1, 4'h2);
    m_rready = 3'b010; m_bready = 3'b001;
    #1;
    check("cc_rvalid", m_rvalid, 3'b001);
    check("cc_bvalid", m_bvalid, 3'b010);
    check("cc_rready_cross", s_rready, 0);
    check("cc_bready_cross", s_bready, 0);
    check("cc_rdata_m1_zero", m_rdata[1*DW +: DW], 0);
    tick();
    check("cc_rdata_hold", m_rdata[0*DW +: DW], 32'hDEAD_BEEF);
    check("cc_bresp_hold", m_bresp, 6'b00_01_00);
    m_rready = 3'b001; m_bready = 3'b010;
    #1;
    check("cc_rready", s_rready, 1);
    check("cc_bready", s_bready, 1);
    tick();
    s_rvalid = 1'b0; s_bvalid = 1'b0; s_rlast = 1'b0;
    #1;
    check("cc_r_idle", s_rready, 0);
    check("cc_b_idle", s_bready, 0);

`ifdef AXI_ARB_IDTAG_EN
    // Response carrying another master's tag is swallowed and flagged.
    set_ar(1, 32'h0000_7000, 4'h5);
    m_arvalid = 3'b010;
    m_rready  = 3'b111;
    tick();
    check("tag_s_arid", s_arid, sid(1, 4'h5));
    tick();
    m_arvalid = '0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = sid(0, 4'h5); s_rdata = 32'h0BAD_0BAD;
    #1;
    check("tag_drop_rvalid", m_rvalid, 0);
    check("tag_drop_rready", s_rready, 1);
    tick();
    check("tag_err_pulse", err_tag, 1);
    s_rid = sid(1, 4'h5); s_rdata = 32'h600D_600D;
    #1;
    check("tag_ok_rvalid", m_rvalid, 3'b010);
    tick();
    check("tag_err_clear", err_tag, 0);
    s_rvalid = 1'b0; s_rlast = 1'b0;
`endif

    // Reset in the middle of a read burst drops the transaction immediately.
    set_ar(2, 32'h0000_8000, 4'h6);
    m_arvalid = 3'b100;
    m_rready  = 3'b111;
    tick();
    tick();
    m_arvalid = '0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rid = sid(2, 4'h6); s_rdata = 32'h7777_7777;
    #1;
    check("mid_rvalid", m_rvalid, 3'b100);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", m_rvalid, 0);
    check("mid_rst_rready", s_rready, 0);
    tick();
    rst = 1'b0;
    s_rvalid = 1'b0;
    tick();
    check("post_rst_idle", s_arvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
